// File: rtl/ucsbece154b_issue_sched.sv
// rtl/ucsbece154b_issue_sched.sv - in-order dual-issue scheduler with a circular decode queue
module ucsbece154b_issue_sched #(
  parameter int DEPTH = 4,
  parameter int CW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid_a,
  input  logic                     in_valid_b,
  input  logic [31:0]              in_pc_a,
  input  logic [31:0]              in_pc_b,
  input  logic [31:0]              in_instr_a,
  input  logic [31:0]              in_instr_b,
  input  logic [4:0]               in_rs1_a,
  input  logic [4:0]               in_rs2_a,
  input  logic [4:0]               in_rd_a,
  input  logic [4:0]               in_rs1_b,
  input  logic [4:0]               in_rs2_b,
  input  logic [4:0]               in_rd_b,
  input  logic                     in_regwrite_a,
  input  logic                     in_regwrite_b,
  input  logic                     in_mem_a,
  input  logic                     in_mem_b,
  input  logic                     in_ctrl_a,
  input  logic                     in_ctrl_b,
  output logic                     in_ready,
  input  logic                     stall_i,
  input  logic                     flush_i,
  output logic                     iss_valid1,
  output logic                     iss_valid2,
  output logic [31:0]              iss_pc1,
  output logic [31:0]              iss_pc2,
  output logic [31:0]              iss_instr1,
  output logic [31:0]              iss_instr2,
  output logic                     hz_raw,
  output logic                     hz_waw,
  output logic                     hz_ctrl,
  output logic                     hz_mem,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CW-1:0]            cnt_cycles,
  output logic [CW-1:0]            cnt_issued,
  output logic [CW-1:0]            cnt_dual,
  output logic [CW-1:0]            cnt_flush
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam logic [OW-1:0] L_OCC_RDY = OW'(DEPTH - 2);
  localparam logic [OW-1:0] L_OCC_ONE = OW'(1);
  localparam logic [AW-1:0] L_PTR_ONE = AW'(1);

  logic [31:0]      r_pc    [DEPTH];
  logic [31:0]      r_instr [DEPTH];
  logic [4:0]       r_rs1   [DEPTH];
  logic [4:0]       r_rs2   [DEPTH];
  logic [4:0]       r_rd    [DEPTH];
  logic [DEPTH-1:0] r_rw;
  logic [DEPTH-1:0] r_mem;
  logic [DEPTH-1:0] r_ctrl;
  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [OW-1:0]    r_occ;

  logic [AW-1:0] w_h1;
  logic [AW-1:0] w_t1;
  logic          w_has1;
  logic          w_has2;
  logic          w_hz_gate;
  logic          w_enq_a;
  logic          w_enq_b;
  logic [1:0]    w_enq_n;
  logic [1:0]    w_deq_n;

  assign w_h1      = r_head + L_PTR_ONE;
  assign w_t1      = r_tail + L_PTR_ONE;
  assign w_has1    = (r_occ != '0);
  assign w_has2    = (r_occ > L_OCC_ONE);
  assign w_hz_gate = w_has2 && !flush_i;

  // Readiness is judged on the pre-dequeue count so a full pair always fits.
  assign in_ready = (r_occ <= L_OCC_RDY);
  assign w_enq_a  = in_ready && !flush_i && in_valid_a;
  assign w_enq_b  = w_enq_a && in_valid_b;
  assign w_enq_n  = {1'b0, w_enq_a} + {1'b0, w_enq_b};

  assign hz_raw  = w_hz_gate && r_rw[r_head] && (r_rd[r_head] != 5'd0) &&
                   ((r_rd[r_head] == r_rs1[w_h1]) || (r_rd[r_head] == r_rs2[w_h1]));
  assign hz_waw  = w_hz_gate && r_rw[r_head] && r_rw[w_h1] && (r_rd[r_head] != 5'd0) &&
                   (r_rd[r_head] == r_rd[w_h1]);
  assign hz_ctrl = w_hz_gate && r_ctrl[r_head];
  assign hz_mem  = w_hz_gate && r_mem[r_head] && r_mem[w_h1];

  assign iss_valid1 = w_has1 && !stall_i && !flush_i;
  assign iss_valid2 = iss_valid1 && w_has2 && !(hz_raw || hz_waw || hz_ctrl || hz_mem);
  assign w_deq_n    = {1'b0, iss_valid1} + {1'b0, iss_valid2};

  assign iss_pc1    = w_has1 ? r_pc[r_head]    : 32'd0;
  assign iss_instr1 = w_has1 ? r_instr[r_head] : 32'd0;
  assign iss_pc2    = w_has2 ? r_pc[w_h1]      : 32'd0;
  assign iss_instr2 = w_has2 ? r_instr[w_h1]   : 32'd0;
  assign occupancy  = r_occ;

  // Payload storage needs no reset: entries are only observed through r_occ.
  always_ff @(posedge clk) begin
    if (w_enq_a) begin
      r_pc[r_tail]    <= in_pc_a;
      r_instr[r_tail] <= in_instr_a;
      r_rs1[r_tail]   <= in_rs1_a;
      r_rs2[r_tail]   <= in_rs2_a;
      r_rd[r_tail]    <= in_rd_a;
      r_rw[r_tail]    <= in_regwrite_a;
      r_mem[r_tail]   <= in_mem_a;
      r_ctrl[r_tail]  <= in_ctrl_a;
    end
    if (w_enq_b) begin
      r_pc[w_t1]    <= in_pc_b;
      r_instr[w_t1] <= in_instr_b;
      r_rs1[w_t1]   <= in_rs1_b;
      r_rs2[w_t1]   <= in_rs2_b;
      r_rd[w_t1]    <= in_rd_b;
      r_rw[w_t1]    <= in_regwrite_b;
      r_mem[w_t1]   <= in_mem_b;
      r_ctrl[w_t1]  <= in_ctrl_b;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_occ      <= '0;
      cnt_cycles <= '0;
      cnt_issued <= '0;
      cnt_dual   <= '0;
      cnt_flush  <= '0;
    end else begin
      cnt_cycles <= cnt_cycles + CW'(1);
      cnt_issued <= cnt_issued + CW'(w_deq_n);
      cnt_dual   <= cnt_dual + CW'(iss_valid1 && iss_valid2);
      if (flush_i) begin
        r_head    <= '0;
        r_tail    <= '0;
        r_occ     <= '0;
        cnt_flush <= cnt_flush + CW'(1);
      end else begin
        r_head <= r_head + AW'(w_deq_n);
        r_tail <= r_tail + AW'(w_enq_n);
        r_occ  <= r_occ + OW'(w_enq_n) - OW'(w_deq_n);
      end
    end
  end

endmodule

// File: tb/tb_ucsbece154b_issue_sched.sv
// tb/tb_ucsbece154b_issue_sched.sv - directed self-checking bench for the dual-issue scheduler
module tb_ucsbece154b_issue_sched;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid_a, in_valid_b;
  logic [31:0] in_pc_a, in_pc_b, in_instr_a, in_instr_b;
  logic [4:0]  in_rs1_a, in_rs2_a, in_rd_a, in_rs1_b, in_rs2_b, in_rd_b;
  logic        in_regwrite_a, in_regwrite_b, in_mem_a, in_mem_b, in_ctrl_a, in_ctrl_b;
  logic        in_ready, stall_i, flush_i;
  logic        iss_valid1, iss_valid2;
  logic [31:0] iss_pc1, iss_pc2, iss_instr1, iss_instr2;
  logic        hz_raw, hz_waw, hz_ctrl, hz_mem;
  logic [2:0]  occupancy;
  logic [31:0] cnt_cycles, cnt_issued, cnt_dual, cnt_flush;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  ucsbece154b_issue_sched #(.DEPTH(4), .CW(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid_a(in_valid_a), .in_valid_b(in_valid_b),
    .in_pc_a(in_pc_a), .in_pc_b(in_pc_b),
    .in_instr_a(in_instr_a), .in_instr_b(in_instr_b),
    .in_rs1_a(in_rs1_a), .in_rs2_a(in_rs2_a), .in_rd_a(in_rd_a),
    .in_rs1_b(in_rs1_b), .in_rs2_b(in_rs2_b), .in_rd_b(in_rd_b),
    .in_regwrite_a(in_regwrite_a), .in_regwrite_b(in_regwrite_b),
    .in_mem_a(in_mem_a), .in_mem_b(in_mem_b),
    .in_ctrl_a(in_ctrl_a), .in_ctrl_b(in_ctrl_b),
    .in_ready(in_ready), .stall_i(stall_i), .flush_i(flush_i),
    .iss_valid1(iss_valid1), .iss_valid2(iss_valid2),
    .iss_pc1(iss_pc1), .iss_pc2(iss_pc2),
    .iss_instr1(iss_instr1), .iss_instr2(iss_instr2),
    .hz_raw(hz_raw), .hz_waw(hz_waw), .hz_ctrl(hz_ctrl), .hz_mem(hz_mem),
    .occupancy(occupancy),
    .cnt_cycles(cnt_cycles), .cnt_issued(cnt_issued),
    .cnt_dual(cnt_dual), .cnt_flush(cnt_flush)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_a(input logic [31:0] pc, input logic [31:0] ins, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic rw,
                       input logic mem, input logic ctrl);
    in_valid_a = 1'b1; in_pc_a = pc; in_instr_a = ins;
    in_rs1_a = rs1; in_rs2_a = rs2; in_rd_a = rd;
    in_regwrite_a = rw; in_mem_a = mem; in_ctrl_a = ctrl;
  endtask

  task automatic set_b(input logic [31:0] pc, input logic [31:0] ins, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic rw,
                       input logic mem, input logic ctrl);
    in_valid_b = 1'b1; in_pc_b = pc; in_instr_b = ins;
    in_rs1_b = rs1; in_rs2_b = rs2; in_rd_b = rd;
    in_regwrite_b = rw; in_mem_b = mem; in_ctrl_b = ctrl;
  endtask

  task automatic pair_nh(input logic [31:0] pc);
    set_a(pc,        32'h00a00513, 5'd1, 5'd2, 5'd10, 1'b1, 1'b0, 1'b0);
    set_b(pc + 32'd4, 32'h00b00593, 5'd3, 5'd4, 5'd11, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic clr_in();
    in_valid_a = 1'b0; in_valid_b = 1'b0;
    in_pc_a = '0; in_pc_b = '0; in_instr_a = '0; in_instr_b = '0;
    in_rs1_a = '0; in_rs2_a = '0; in_rd_a = '0;
    in_rs1_b = '0; in_rs2_b = '0; in_rd_b = '0;
    in_regwrite_a = 1'b0; in_regwrite_b = 1'b0;
    in_mem_a = 1'b0; in_mem_b = 1'b0; in_ctrl_a = 1'b0; in_ctrl_b = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    clr_in();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_occ", occupancy, 0);
    chk("rst_valid", {iss_valid1, iss_valid2}, 0);
    chk("rst_hz", {hz_raw, hz_waw, hz_ctrl, hz_mem}, 0);
    chk("rst_cnt", cnt_cycles | cnt_issued | cnt_dual | cnt_flush, 0);
    @(negedge clk);
    reset = 1'b0;

    // independent pair dual-issues
    set_a(32'h100, 32'h00100293, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
    set_b(32'h104, 32'h00200313, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
    tick(); clr_in(); #1;
    chk("t1_occ", occupancy, 2);
    chk("t1_valid", {iss_valid1, iss_valid2}, 2'b11);
    chk("t1_hz", {hz_raw, hz_waw, hz_ctrl, hz_mem}, 0);
    chk("t1_pc1", iss_pc1, 32'h100);
    chk("t1_pc2", iss_pc2, 32'h104);
    chk("t1_ins1", iss_instr1, 32'h00100293);
    chk("t1_ins2", iss_instr2, 32'h00200313);
    tick();
    chk("t1_occ_after", occupancy, 0);
    chk("t1_dual", cnt_dual, 1);
    chk("t1_issued", cnt_issued, 2);
    chk("t1_idle_v1", iss_valid1, 0);
    chk("t1_idle_pc1", iss_pc1, 0);

    // RAW
    set_a(32'h200, 32'h00100293, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
    set_b(32'h204, 32'h00128313, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
    tick(); clr_in(); #1;
    chk("raw_valid", {iss_valid1, iss_valid2}, 2'b10);
    chk("raw_hz", {hz_raw, hz_waw, hz_ctrl, hz_mem}, 4'b1000);
    tick();
    chk("raw_occ1", occupancy, 1);
    chk("raw_b_valid", {iss_valid1, iss_valid2}, 2'b10);
    chk("raw_b_pc1", iss_pc1, 32'h204);
    chk("raw_b_pc2", iss_pc2, 0);
    chk("raw_b_hz", hz_raw, 0);
    tick();
    chk("raw_issued", cnt_issued, 4);
    chk("raw_dual", cnt_dual, 1);

    // WAW
    set_a(32'h300, 32'h002083b3, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0);
    set_b(32'h304, 32'h004183b3, 5'd3, 5'd4, 5'd7, 1'b1, 1'b0, 1'b0);
    tick(); clr_in(); #1;
    chk("waw_hz", {hz_raw, hz_waw, hz_ctrl, hz_mem}, 4'b0100);
    chk("waw_v2", iss_valid2, 0);
    tick(); tick();

    // rd=x0 never creates a hazard
    set_a(32'h310, 32'h00100013, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    set_b(32'h314, 32'h00000193, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0);
    tick(); clr_in(); #1;
    chk("x0_valid", {iss_valid1, iss_valid2}, 2'b11);
    chk("x0_hz", {hz_raw, hz_waw, hz_ctrl, hz_mem}, 0);
    tick();

    // WAR is not a hazard
    set_a(32'h320, 32'h00018213, 5'd3, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0);
    set_b(32'h324, 32'h002081b3, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
    tick(); clr_in(); #1;
    chk("war_valid", {iss_valid1, iss_valid2}, 2'b11);
    chk("war_hz", {hz_raw, hz_waw, hz_ctrl, hz_mem}, 0);
    tick();

    // control flow in slot 1
    set_a(32'h330, 32'h00208463, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1);
    set_b(32'h334, 32'h004182b3, 5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 1'b0);
    tick(); clr_in(); #1;
    chk("ctrl_hz", {hz_raw, hz_waw, hz_ctrl, hz_mem}, 4'b0010);
    chk("ctrl_valid", {iss_valid1, iss_valid2}, 2'b10);
    chk("ctrl_pc1", iss_pc1, 32'h330);
    tick(); tick();

    // both memory
    set_a(32'h340, 32'h00012403, 5'd2, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0);
    set_b(32'h344, 32'h00912023, 5'd2, 5'd9, 5'd0, 1'b0, 1'b1, 1'b0);
    tick(); clr_in(); #1;
    chk("mem_hz", {hz_raw, hz_waw, hz_ctrl, hz_mem}, 4'b0001);
    chk("mem_valid", {iss_valid1, iss_valid2}, 2'b10);
    tick(); tick();
    chk("mid_issued", cnt_issued, 14);
    chk("mid_dual", cnt_dual, 3);
    chk("mid_occ", occupancy, 0);

    // stall fills the queue, third pair dropped
    stall_i = 1'b1;
    pair_nh(32'h400);
    tick(); pair_nh(32'h408); #1;
    chk("st_occ2", occupancy, 2);
    chk("st_ready2", in_ready, 1);
    chk("st_valid", {iss_valid1, iss_valid2}, 0);
    tick(); pair_nh(32'h410); #1;
    chk("st_occ4", occupancy, 4);
    chk("st_ready4", in_ready, 0);
    tick(); clr_in(); stall_i = 1'b0; #1;
    chk("st_occ_hold", occupancy, 4);
    chk("st_r1_valid", {iss_valid1, iss_valid2}, 2'b11);
    chk("st_r1_pc1", iss_pc1, 32'h400);
    chk("st_r1_pc2", iss_pc2, 32'h404);
    tick();
    chk("st_r2_pc1", iss_pc1, 32'h408);
    chk("st_r2_pc2", iss_pc2, 32'h40c);
    tick();
    chk("st_drop_occ", occupancy, 0);
    chk("st_issued", cnt_issued, 18);
    chk("st_dual", cnt_dual, 5);

    // odd offset so the tail and H1 wrap from entry 3 to 0
    set_a(32'h500, 32'h00000013, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick(); clr_in(); #1;
    chk("sg_occ", occupancy, 1);
    chk("sg_pc1", iss_pc1, 32'h500);
    chk("sg_v2", iss_valid2, 0);
    tick();
    stall_i = 1'b1;
    pair_nh(32'h510);
    tick(); pair_nh(32'h518);
    tick(); clr_in(); stall_i = 1'b0; #1;
    chk("wr_occ", occupancy, 4);
    chk("wr_pc1a", iss_pc1, 32'h510);
    chk("wr_pc2a", iss_pc2, 32'h514);
    tick();
    chk("wr_pc1b", iss_pc1, 32'h518);
    chk("wr_pc2b", iss_pc2, 32'h51c);
    chk("wr_valid", {iss_valid1, iss_valid2}, 2'b11);
    tick();
    chk("wr_issued", cnt_issued, 23);
    chk("cycles", cnt_cycles, cyc);

    // flush with occupancy 3
    stall_i = 1'b1;
    set_a(32'h600, 32'h00208463, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1);
    set_b(32'h604, 32'h004182b3, 5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 1'b0);
    tick(); clr_in();
    set_a(32'h608, 32'h00000013, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick(); clr_in(); #1;
    chk("fl_occ3", occupancy, 3);
    chk("fl_ready", in_ready, 0);
    chk("fl_hz_stall", {hz_raw, hz_waw, hz_ctrl, hz_mem}, 4'b0010);
    stall_i = 1'b0; flush_i = 1'b1;
    pair_nh(32'h610); #1;
    chk("fl_valid", {iss_valid1, iss_valid2}, 0);
    chk("fl_hz", {hz_raw, hz_waw, hz_ctrl, hz_mem}, 0);
    tick(); flush_i = 1'b0; clr_in(); #1;
    chk("fl_occ0", occupancy, 0);
    chk("fl_cnt", cnt_flush, 1);
    chk("fl_ready_after", in_ready, 1);
    chk("fl_issued", cnt_issued, 23);

    // after flush the queue restarts at entry 0; a flush drops a ready pair
    pair_nh(32'h700);
    tick(); clr_in(); #1;
    chk("rs_pc1", iss_pc1, 32'h700);
    chk("rs_pc2", iss_pc2, 32'h704);
    flush_i = 1'b1;
    pair_nh(32'h710);
    tick(); flush_i = 1'b0; clr_in(); #1;
    chk("fl2_occ", occupancy, 0);
    chk("fl2_cnt", cnt_flush, 2);
    chk("fl2_issued", cnt_issued, 23);

    // asynchronous reset mid-stream
    pair_nh(32'h800);
    tick(); clr_in(); #1;
    chk("ar_pre_v1", iss_valid1, 1);
    reset = 1'b1;
    #1;
    chk("ar_occ", occupancy, 0);
    chk("ar_valid", {iss_valid1, iss_valid2}, 0);
    chk("ar_pc1", iss_pc1, 0);
    chk("ar_ready", in_ready, 1);
    chk("ar_cnt", cnt_cycles | cnt_issued | cnt_dual | cnt_flush, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("ar_resume_cycles", cnt_cycles, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ucsbece154b_issue_sched.md
Name: ucsbece154b_issue_sched

Overview:
- In-order dual-issue scheduler between the fetch/decode pair and the two execute lanes of the superscalar pipeline.
- Buffers decoded instructions in a small circular queue and issues 0, 1 or 2 per cycle, oldest first.
- Slot 2 is held back when it has a RAW or WAW conflict with slot 1, when slot 1 is control-flow, or when both slots need the single memory port.
- Drives per-lane valids and hazard flags, and keeps performance counters for the testbench.

Parameters:
- DEPTH, 4, queue entries; power of two, at least 2.
- CW, 32, performance counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid_a  in  1  older decoded instruction present.
- in_valid_b  in  1  younger decoded instruction present; ignored unless in_valid_a=1.
- in_pc_a, in_pc_b  in  32 each  instruction PCs.
- in_instr_a, in_instr_b  in  32 each  raw instruction words.
- in_rs1_a, in_rs2_a, in_rd_a, in_rs1_b, in_rs2_b, in_rd_b  in  5 each  register indices.
- in_regwrite_a, in_regwrite_b  in  1 each  instruction writes rd.
- in_mem_a, in_mem_b  in  1 each  load or store.
- in_ctrl_a, in_ctrl_b  in  1 each  branch, jal or jalr.
- in_ready  out  1  asserted when free entries >= 2.
- stall_i  in  1  execute lanes cannot accept; nothing dequeues.
- flush_i  in  1  mispredict; empties the queue.
- iss_valid1, iss_valid2  out  1 each  lane 1 / lane 2 issuing this cycle.
- iss_pc1, iss_pc2, iss_instr1, iss_instr2  out  32 each  payload of the issuing entries.
- hz_raw, hz_waw, hz_ctrl, hz_mem  out  1 each  reason slot 2 was held.
- occupancy  out  $clog2(DEPTH)+1  entries currently held.
- cnt_cycles, cnt_issued, cnt_dual, cnt_flush  out  CW each  performance counters.

Behaviour:
- Reset values: queue empty, head and tail pointers 0, occupancy 0, every counter 0, in_ready 1, iss_valid1/2 and all hz_* 0.
- Enqueue happens on a rising edge when in_ready=1 and flush_i=0.
  - Accepts A only, or A then B (2 entries).
  - in_valid_b without in_valid_a enqueues nothing.
  - If in_ready=0 the inputs are dropped; upstream must hold them.
- in_ready uses occupancy before this cycle's dequeue (conservative). There is no same-cycle bypass: an entry written at edge N can issue in the cycle after edge N at the earliest.
- Head entries are H0 (oldest) and H1.
- iss_valid1 = (occupancy >= 1) and !stall_i and !flush_i.
- iss_valid2 = iss_valid1 and (occupancy >= 2) and no hazard.
- Hazard conditions between H0 and H1:
  - RAW: H0.regwrite, H0.rd != 0, and H0.rd equals H1.rs1 or H1.rs2.
  - WAW: both write, H0.rd != 0, and H0.rd == H1.rd.
  - ctrl: H0.ctrl = 1.
  - mem: H0.mem and H1.mem.
  - WAR is not a hazard for in-order issue and is never flagged.
- hz_* flags are combinational, driven only when occupancy >= 2 and !flush_i. Several may be 1 at once. They are driven even when stall_i=1.
- iss_pc/instr outputs are driven from H0/H1 whenever those entries are valid, otherwise 0.
- Dequeue happens on the edge: head advances by iss_valid1 + iss_valid2. Pointers wrap modulo DEPTH.
- Occupancy next = occupancy + enqueued - dequeued. This never exceeds DEPTH and never underflows.
- flush_i has highest priority: at the edge, head = tail = occupancy = 0, and enqueue and dequeue are suppressed. cnt_flush increments by 1.
- Counters:
  - cnt_cycles +1 every edge out of reset.
  - cnt_issued + (iss_valid1 + iss_valid2).
  - cnt_dual +1 when both lanes issue.
  - All counters wrap at 2^CW.
- Reset asserted mid-operation: all state clears immediately (asynchronous) and outputs take their reset values. Operation resumes on the first edge after deassertion.

Test Plan:
- Reset, then enqueue pair A=addi x5,x0,1 (rd=5), B=addi x6,x0,2 (rd=6) -> next cycle iss_valid1=iss_valid2=1, no hz_*, cnt_dual=1, occupancy back to 0.
- A writes x5, B reads rs1=x5 -> cycle 1: iss_valid2=0, hz_raw=1. Cycle 2: B issues on lane 1. cnt_issued=2, cnt_dual=0.
- A rd=7 and B rd=7 both writing -> hz_waw=1. Also A rd=0 and B rs1=0 -> no hazard, dual issue.
- A=beq (ctrl) then B=add -> hz_ctrl=1, single issue. Also A=lw, B=sw -> hz_mem=1, single issue.
- Hold stall_i=1 while enqueueing two pairs -> occupancy=4, in_ready=0; a third pair is dropped. Release stall -> issue resumes in order, pointers wrap past entry 3, and PCs leave in enqueue order.
- With occupancy=3, pulse flush_i together with a valid pair -> next cycle occupancy=0, pair not enqueued, cnt_flush=1. Assert reset mid-stream -> all outputs 0 with no clock edge.
